// File: rtl/game_timer_pkg.sv
// game_timer_pkg: state encoding and count-direction constants shared by the game timer.
package game_timer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk25 by CLK_HZ, flagging the enabled cycle that wraps the count.
module tick_prescaler #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk25,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
  logic [PW-1:0] cnt_q, cnt_d;
  assign tick = en && !clr && cnt_q == LAST;
  always_comb begin
    cnt_d = clr ? '0 : en ? (tick ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: up/down game clock with start/stop/pause/clear/load control and
// single-cycle tick and expiry pulses.
module game_timer_ctrl #(
  parameter int CLK_HZ = 25_000_000,
  parameter int SEC_W  = 8
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             clear,
  input  logic             load,
  input  logic [SEC_W-1:0] load_val,
  input  logic             dir,
  input  logic [SEC_W-1:0] limit,
  output logic [SEC_W-1:0] seconds,
  output logic             sec_tick,
  output logic             expired,
  output logic             running,
  output logic [1:0]       state
);
  import game_timer_pkg::*;
  state_e state_q, state_d;
  logic [SEC_W-1:0] seconds_q, seconds_d, start_val, step_val;
  logic dir_q, dir_d, sec_tick_q, sec_tick_d, expired_q, expired_d, running_q, running_d;
  logic active, can_start, pre_en, pre_clr, pre_tick;
  assign active    = state_q == RUN || state_q == PAUSE;
  assign can_start = start && !active;
  // The prescaler only advances on cycles where no command overrides counting.
  assign pre_en    = !clear && !stop && !load && active && !pause;
  assign pre_clr   = clear || stop || can_start;
  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
    .clk25  (clk25),
    .reset_n(reset_n),
    .en     (pre_en),
    .clr    (pre_clr),
    .tick   (pre_tick)
  );
  always_comb begin
    state_d    = state_q;
    seconds_d  = seconds_q;
    dir_d      = dir_q;
    sec_tick_d = 1'b0;
    expired_d  = 1'b0;
    start_val  = load ? load_val : seconds_q;
    step_val   = dir_q ? seconds_q - 1'b1 : seconds_q + 1'b1;
    if (clear) begin
      seconds_d = '0;
      state_d   = IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end else if (load || can_start) begin
      seconds_d = start_val;
      if (can_start) begin
        dir_d     = dir;
        expired_d = dir == DIR_DOWN && start_val == '0;
        state_d   = (dir == DIR_DOWN && start_val == '0) ? EXPIRED : RUN;
      end
    end else if (active) begin
      state_d = pause ? PAUSE : RUN;
      if (pre_tick) begin
        sec_tick_d = 1'b1;
        seconds_d  = step_val;
        if (dir_q ? step_val == '0 : (limit != '0 && step_val == limit)) begin
          state_d   = EXPIRED;
          expired_d = 1'b1;
        end
      end
    end
    running_d = state_d == RUN;
  end
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      seconds_q  <= '0;
      dir_q      <= DIR_UP;
      sec_tick_q <= 1'b0;
      expired_q  <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      seconds_q  <= seconds_d;
      dir_q      <= dir_d;
      sec_tick_q <= sec_tick_d;
      expired_q  <= expired_d;
      running_q  <= running_d;
    end
  end
  assign seconds  = seconds_q;
  assign sec_tick = sec_tick_q;
  assign expired  = expired_q;
  assign running  = running_q;
  assign state    = state_q;
endmodule
